// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file / busy scoreboard slice.
//   rf_state_e          : clear engine state encoding (RF_IDLE, RF_CLEAR)
//   RF_DEFAULT_WIDTH    : default data width of each register
//   RF_DEFAULT_ADDR_W   : default register address width
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int RF_DEFAULT_WIDTH  = 32;
   localparam int RF_DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
// Bundles the issue, writeback, read and clear-control signals of the
// register file.
//   master : decode/issue + writeback side (drives requests, reads results)
//   slave  : the register file itself
// Signals:
//   we/waddr/wdata           writeback port
//   issue_valid/issue_addr   destination marking at issue
//   raddr0/1 -> rdata0/1, rbusy0/1   operand read ports
//   dbg_addr -> dbg_data     debug read port (never bypassed)
//   clear_start -> clear_busy, wr_drop   sequential clear control/status
// ---------------------------------------------------------------------------
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int WIDTH  = RF_DEFAULT_WIDTH,
   parameter int ADDR_W = RF_DEFAULT_ADDR_W
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] raddr0;
   logic [ADDR_W-1:0] raddr1;
   logic [WIDTH-1:0]  rdata0;
   logic [WIDTH-1:0]  rdata1;
   logic              rbusy0;
   logic              rbusy1;
   logic [ADDR_W-1:0] dbg_addr;
   logic [WIDTH-1:0]  dbg_data;
   logic              clear_start;
   logic              clear_busy;
   logic              wr_drop;

   modport master (
      output we, waddr, wdata, issue_valid, issue_addr,
      output raddr0, raddr1, dbg_addr, clear_start,
      input  rdata0, rdata1, rbusy0, rbusy1, dbg_data, clear_busy, wr_drop
   );

   modport slave (
      input  we, waddr, wdata, issue_valid, issue_addr,
      input  raddr0, raddr1, dbg_addr, clear_start,
      output rdata0, rdata1, rbusy0, rbusy1, dbg_data, clear_busy, wr_drop
   );

endinterface

// File: rtl/regfile_clear_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clear_fsm
// Sequential clear engine. Walks registers 1..DEPTH-1, one per cycle, and
// reports requests that arrive while it owns the array.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear_start    request a clear (ignored while already clearing)
//   we/issue_valid observed only to flag discarded requests
//   clr_en         array should clear register clr_addr this cycle
//   clr_addr       register being cleared
//   clear_busy     engine active
//   wr_drop        one-cycle pulse after a discarded we/issue_valid
// ---------------------------------------------------------------------------
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_DEFAULT_ADDR_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_start,
   input  logic              we,
   input  logic              issue_valid,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              clear_busy,
   output logic              wr_drop
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   rf_state_e         state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              wr_drop_q;

   // The clear starts at register 1 since register 0 is hard-wired to zero.
   // Leaving CLEAR happens on the same edge that clears the last register,
   // so the whole sweep takes DEPTH-1 cycles. wr_drop is registered so it
   // lands one cycle after the discarded request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RF_IDLE;
         cnt_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         case (state_q)
            RF_IDLE: begin
               wr_drop_q <= 1'b0;
               if (clear_start) begin
                  state_q <= RF_CLEAR;
                  cnt_q   <= ADDR_W'(1);
               end
            end
            RF_CLEAR: begin
               wr_drop_q <= we | issue_valid;
               if (cnt_q == LAST_ADDR) begin
                  state_q <= RF_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= RF_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Status is taken straight from the flops.
   assign clr_en     = (state_q == RF_CLEAR);
   assign clr_addr   = cnt_q;
   assign clear_busy = (state_q == RF_CLEAR);
   assign wr_drop    = wr_drop_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Register file with a per-register busy scoreboard, optional writeback
// bypass to the operand ports and a sequential clear engine.
// Parameters: WIDTH (data width), ADDR_W (address width, DEPTH = 2**ADDR_W),
//             BYPASS (1 = forward same-cycle writeback to operand ports).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         regfile_if.slave (issue, writeback, reads, clear control)
// ---------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int WIDTH  = RF_DEFAULT_WIDTH,
   parameter int ADDR_W = RF_DEFAULT_ADDR_W,
   parameter bit BYPASS = 1'b1
)(
   input  logic     clk,
   input  logic     reset,
   regfile_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [WIDTH-1:0]  regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok;
   logic              issue_ok;
   logic              hit0;
   logic              hit1;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk         (clk),
      .reset       (reset),
      .clear_start (bus.clear_start),
      .we          (bus.we),
      .issue_valid (bus.issue_valid),
      .clr_en      (clr_en),
      .clr_addr    (clr_addr),
      .clear_busy  (bus.clear_busy),
      .wr_drop     (bus.wr_drop)
   );

   // Writes and issues only count when the clear engine is idle; register 0
   // is never a legal target.
   assign wr_ok    = bus.we && !clr_en && (bus.waddr != '0);
   assign issue_ok = bus.issue_valid && !clr_en && (bus.issue_addr != '0);

   // Next array/scoreboard contents. The issue is applied after the write so
   // a same-cycle issue to the writeback target leaves the register busy:
   // the newly issued producer is the one still outstanding.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (clr_en) begin
         regs_d[clr_addr] = '0;
         busy_d[clr_addr] = 1'b0;
      end else begin
         if (wr_ok) begin
            regs_d[bus.waddr] = bus.wdata;
            busy_d[bus.waddr] = 1'b0;
         end
         if (issue_ok) begin
            busy_d[bus.issue_addr] = 1'b1;
         end
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   // Storage update; reset wipes everything in one edge, which also aborts
   // any clear in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Forwarding is disabled during a clear so readers see the stored,
   // partially cleared contents.
   assign hit0 = BYPASS && !clr_en && bus.we &&
                 (bus.waddr == bus.raddr0) && (bus.raddr0 != '0);
   assign hit1 = BYPASS && !clr_en && bus.we &&
                 (bus.waddr == bus.raddr1) && (bus.raddr1 != '0);

   assign bus.rdata0   = hit0 ? bus.wdata : regs_q[bus.raddr0];
   assign bus.rdata1   = hit1 ? bus.wdata : regs_q[bus.raddr1];
   assign bus.rbusy0   = hit0 ? 1'b0 : busy_q[bus.raddr0];
   assign bus.rbusy1   = hit1 ? 1'b0 : busy_q[bus.raddr1];
   assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule
